// File: rtl/xilinx_fifo_rd_axis.sv
// Read-side adapter for the Xilinx FIFO wrapper: turns the fixed-latency rd_en/dout
// port into a valid/ready stream through a small credit-checked prefetch buffer.
module xilinx_fifo_rd_axis #(
   parameter int DSIZE  = 18,
   parameter int RD_LAT = 1
) (
   input  logic                        clock,
   input  logic                        rst_n,
   input  logic                        fifo_empty,
   output logic                        fifo_rd_en,
   input  logic [DSIZE-1:0]            fifo_dout,
   output logic                        m_tvalid,
   input  logic                        m_tready,
   output logic [DSIZE-1:0]            m_tdata,
   output logic [$clog2(RD_LAT+3)-1:0] level
);

   localparam int BDEPTH = RD_LAT + 2;
   localparam int CW     = $clog2(BDEPTH + 1);
   localparam int PW     = $clog2(BDEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(BDEPTH - 1);
   localparam logic [CW:0]   CREDITS  = (CW+1)'(BDEPTH);

   logic [RD_LAT-1:0] r_infl;
   logic [DSIZE-1:0]  r_buf [BDEPTH];
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic [CW-1:0]     w_inflight;
   logic              w_land;
   logic              w_pop;

   // BDEPTH is generally not a power of two, so the wrap is an explicit compare.
   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < RD_LAT; i++) w_inflight = w_inflight + CW'(r_infl[i]);
   end

   // Credit check uses only registered state, so m_tready never reaches fifo_rd_en.
   assign fifo_rd_en = rst_n && !fifo_empty &&
                       (({1'b0, r_count} + {1'b0, w_inflight}) < CREDITS);

   assign w_land   = r_infl[RD_LAT-1];
   assign w_pop    = m_tvalid && m_tready;
   assign m_tvalid = (r_count != '0);
   assign m_tdata  = r_buf[r_rd_ptr];
   assign level    = r_count;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_infl   <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < BDEPTH; i++) r_buf[i] <= '0;
      end else begin
         r_infl <= RD_LAT'({r_infl, fifo_rd_en});
         if (w_land) begin
            r_buf[r_wr_ptr] <= fifo_dout;
            r_wr_ptr        <= ptr_next(r_wr_ptr);
         end
         if (w_pop) r_rd_ptr <= ptr_next(r_rd_ptr);
         if (w_land && !w_pop)      r_count <= r_count + CW'(1);
         else if (!w_land && w_pop) r_count <= r_count - CW'(1);
      end
   end

endmodule

// File: tb/tb_xilinx_fifo_rd_axis.sv
// Bench for xilinx_fifo_rd_axis: one DUT per RD_LAT (1..3), each fed by a queue-based
// FIFO emulation and checked every cycle against a queue-level model of the adapter.
module tb_xilinx_fifo_rd_axis;

   localparam int DSIZE = 18;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_lat
      localparam int L  = g + 1;
      localparam int BD = L + 2;
      localparam int LW = $clog2(BD + 1);

      logic             rst_n;
      logic             fifo_empty;
      logic             fifo_rd_en;
      logic [DSIZE-1:0] fifo_dout;
      logic             m_tvalid;
      logic             m_tready;
      logic [DSIZE-1:0] m_tdata;
      logic [LW-1:0]    level;
      bit               done;

      xilinx_fifo_rd_axis #(.DSIZE(DSIZE), .RD_LAT(L)) u_dut (
         .clock      (clk),
         .rst_n      (rst_n),
         .fifo_empty (fifo_empty),
         .fifo_rd_en (fifo_rd_en),
         .fifo_dout  (fifo_dout),
         .m_tvalid   (m_tvalid),
         .m_tready   (m_tready),
         .m_tdata    (m_tdata),
         .level      (level)
      );

      logic [DSIZE-1:0] fq[$];        // words held by the emulated FIFO
      logic [DSIZE-1:0] mbuf[$];      // model: words presented/buffered, head first
      logic [DSIZE-1:0] iss_word[$];  // model: words of issued reads not yet landed
      int               iss_cyc[$];   // model: cycle each of those reads was issued
      logic [DSIZE-1:0] dpipe [3];
      int               cyc;
      bit               force_empty;
      bit               obs_rd;
      bit               obs_acc;
      logic [DSIZE-1:0] obs_word;
      string            pfx;

      task automatic push_rand(input int n);
         for (int i = 0; i < n; i++) fq.push_back(DSIZE'($urandom));
      endtask

      // One clock cycle: drive inputs, check outputs against the model, advance both.
      task automatic step(input bit rdy);
         bit ex_rd;
         bit land;
         @(negedge clk);
         m_tready   = rdy;
         fifo_empty = (fq.size() == 0) || force_empty;
         fifo_dout  = dpipe[L-1];
         #1;
         ex_rd = rst_n && !fifo_empty && ((mbuf.size() + iss_cyc.size()) < BD);
         check({pfx, "rd_en"}, 32'(fifo_rd_en), 32'(ex_rd));
         check({pfx, "rd_while_empty"}, 32'(fifo_rd_en & fifo_empty), 0);
         check({pfx, "tvalid"}, 32'(m_tvalid), 32'(mbuf.size() != 0));
         check({pfx, "level"}, 32'(level), mbuf.size());
         check({pfx, "level_max"}, 32'(level <= LW'(BD)), 1);
         if (mbuf.size() != 0) check({pfx, "tdata"}, 32'(m_tdata), 32'(mbuf[0]));
         obs_rd   = fifo_rd_en;
         obs_acc  = m_tvalid && rdy;
         obs_word = m_tdata;
         for (int i = 2; i > 0; i--) dpipe[i] = dpipe[i-1];
         if (!rst_n) begin
            mbuf.delete();
            iss_cyc.delete();
            iss_word.delete();
            dpipe[0] = DSIZE'($urandom);
         end else begin
            land = (iss_cyc.size() != 0) && (iss_cyc[0] == cyc - L);
            if (mbuf.size() != 0 && rdy) void'(mbuf.pop_front());
            if (land) begin
               mbuf.push_back(iss_word.pop_front());
               void'(iss_cyc.pop_front());
            end
            if (ex_rd) begin
               iss_cyc.push_back(cyc);
               iss_word.push_back(fq[0]);
            end
            if (fifo_rd_en && fq.size() != 0) dpipe[0] = fq.pop_front();
            else                              dpipe[0] = DSIZE'($urandom);
         end
         cyc++;
      endtask

      initial begin
         int first;
         int last;
         int cnt;
         int cnt2;
         int nv;
         int lvl_mid;
         int sent;
         int got;
         logic [DSIZE-1:0] w0;

         pfx         = $sformatf("L%0d.", L);
         done        = 1'b0;
         m_tready    = 1'b0;
         fifo_empty  = 1'b1;
         fifo_dout   = '0;
         force_empty = 1'b0;
         cyc         = 0;
         for (int i = 0; i < 3; i++) dpipe[i] = '0;
         rst_n = 1'b1;
         #1 rst_n = 1'b0;

         step(1'b0);
         step(1'b0);
         check({pfx, "rst_tdata"}, 32'(m_tdata), 0);
         check({pfx, "rst_tvalid"}, 32'(m_tvalid), 0);
         check({pfx, "rst_level"}, 32'(level), 0);
         rst_n = 1'b1;

         // Basic latency: three words, consumer always ready.
         fq.push_back(DSIZE'(1));
         fq.push_back(DSIZE'(2));
         fq.push_back(DSIZE'(3));
         cnt = 0; cnt2 = 0; nv = 0; first = -1;
         for (int k = 0; k < 12; k++) begin
            step(1'b1);
            if (obs_rd) begin
               if (k <= 2) cnt++;
               else        cnt2++;
            end
            if (obs_acc) begin
               if (first < 0) first = k;
               check({pfx, "basic_data"}, 32'(obs_word), nv + 1);
               nv++;
            end
         end
         check({pfx, "basic_rd_cyc0_2"}, cnt, 3);
         check({pfx, "basic_rd_later"}, cnt2, 0);
         check({pfx, "basic_first_vld"}, first, L + 1);
         check({pfx, "basic_nvld"}, nv, 3);
         check({pfx, "basic_level_end"}, 32'(level), 0);

         // Back-pressure: credits exhausted, head word held stable.
         push_rand(20);
         w0  = fq[0];
         cnt = 0;
         for (int k = 0; k < 10; k++) begin
            step(1'b0);
            if (obs_rd) cnt++;
         end
         check({pfx, "bp_reads"}, cnt, BD);
         check({pfx, "bp_level"}, 32'(level), BD);
         check({pfx, "bp_head"}, 32'(m_tdata), 32'(w0));
         check({pfx, "bp_rd_off"}, 32'(fifo_rd_en), 0);
         first = -1; last = -1; cnt = 0;
         for (int k = 0; k < 100 && cnt < 20; k++) begin
            step(1'b1);
            if (obs_acc) begin
               if (first < 0) first = k;
               last = k;
               cnt++;
            end
         end
         check({pfx, "bp_count"}, cnt, 20);
         check({pfx, "bp_gapless"}, last - first + 1, 20);

         // Throughput: 100 words streamed back to back.
         push_rand(100);
         first = -1; last = -1; cnt = 0; lvl_mid = -1;
         for (int k = 0; k < 300 && cnt < 100; k++) begin
            step(1'b1);
            if (obs_acc) begin
               if (first < 0) first = k;
               last = k;
               cnt++;
            end
            if (k == L + 50) lvl_mid = int'(level);
         end
         check({pfx, "tp_first"}, first, L + 1);
         check({pfx, "tp_span"}, last - first + 1, 100);
         check({pfx, "tp_level_steady"}, lvl_mid, 1);

         // Mid-operation reset with words buffered and reads in flight.
         push_rand(10);
         for (int k = 0; k < L + 3; k++) step(1'b0);
         @(posedge clk);
         #2;
         check({pfx, "prerst_level"}, 32'(level), mbuf.size());
         rst_n = 1'b0;
         #1;
         check({pfx, "rst_async_tvalid"}, 32'(m_tvalid), 0);
         check({pfx, "rst_async_level"}, 32'(level), 0);
         check({pfx, "rst_async_rd_en"}, 32'(fifo_rd_en), 0);
         check({pfx, "rst_async_tdata"}, 32'(m_tdata), 0);
         fq.delete();
         mbuf.delete();
         iss_cyc.delete();
         iss_word.delete();
         step(1'b1);
         step(1'b1);
         rst_n = 1'b1;
         push_rand(5);
         w0 = fq[0];
         first = -1; cnt = 0;
         for (int k = 0; k < 40 && cnt < 5; k++) begin
            step(1'b1);
            if (obs_acc) begin
               if (first < 0) begin
                  first = k;
                  check({pfx, "rst_new_first"}, 32'(obs_word), 32'(w0));
               end
               cnt++;
            end
         end
         check({pfx, "rst_new_latency"}, first, L + 1);
         check({pfx, "rst_new_count"}, cnt, 5);

         // Random ready, random FIFO arrival and empty-flag toggling.
         sent = 0; got = 0;
         for (int k = 0; k < 20000 && got < 1000; k++) begin
            if (sent < 1000 && $urandom_range(0, 2) != 0) begin
               push_rand(1);
               sent++;
            end
            force_empty = ($urandom_range(0, 3) == 0);
            step($urandom_range(0, 1) == 1);
            if (obs_acc) got++;
         end
         force_empty = 1'b0;
         check({pfx, "rand_delivered"}, got, 1000);
         check({pfx, "rand_fifo_drained"}, fq.size(), 0);

         done = 1'b1;
      end
   end

   initial begin
      bit all_done;
      all_done = 1'b0;
      for (int c = 0; c < 60000 && !all_done; c++) begin
         @(posedge clk);
         all_done = g_lat[0].done && g_lat[1].done && g_lat[2].done;
      end
      check("all_done", 32'(all_done), 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
